// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants
// Purpose: receiver state encoding and frame constants; intended to be shared
//          with the matching 8N1 transmitter.
// Ports:   none (package).
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_state_e;

    localparam int   UART_DATA_BITS  = 8;
    localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_sync2.sv
// rtl/uart_sync2.sv - two-flop synchroniser for an asynchronous input
// Purpose: brings an asynchronous level into the clk domain through two flops.
// Parameters:
//   reset_value  level both flops take in reset (idle level of the input)
// Ports:
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset
//   d      in  asynchronous input
//   q      out synchronised copy of d, two clocks late
module uart_sync2 #(
    parameter logic reset_value = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= reset_value;
            q    <= reset_value;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with mid-bit sampling
// Purpose: synchronises in_rx, qualifies start bits, samples each bit at its
//          middle and presents every good byte with a one-cycle valid pulse.
// Optional feature: define UART_RX_CHECKSUM_EN to add out_sum, a running
//          modulo-2^32 sum of all correctly received bytes.
// Parameters:
//   clocks_per_bit  clocks per serial bit (2..65535), equal to the transmitter
// Ports:
//   clk            in   system clock
//   rst_n          in   asynchronous active-low reset
//   in_rx          in   serial line, asynchronous, idle high
//   out_data       out  last correctly framed byte
//   out_valid      out  one-cycle pulse, out_data updated
//   out_frame_err  out  one-cycle pulse, stop bit sampled low
//   out_rx_busy    out  receiver not in IDLE
//   out_sum        out  running byte sum (UART_RX_CHECKSUM_EN only)
module uart_rx
    import uart_pkg::*;
#(
    parameter int clocks_per_bit = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_rx,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        out_frame_err,
`ifdef UART_RX_CHECKSUM_EN
    output logic [31:0] out_sum,
`endif
    output logic        out_rx_busy
);

    localparam int CW   = $clog2(clocks_per_bit);
    localparam int HALF = clocks_per_bit / 2;

    // Start bit is re-checked half a bit after the edge; every later sample
    // is a full bit apart, which lands each one mid-bit.
    localparam logic [CW-1:0] HALF_LOAD = CW'(HALF - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(clocks_per_bit - 1);
    localparam logic [3:0]    LAST_BIT  = 4'(UART_DATA_BITS - 1);

    logic              rx_s;
    uart_state_e       state;
    logic [CW-1:0]     cycle_count;
    logic [3:0]        bit_count;
    logic [7:0]        shift_reg;
    logic              sample;
    logic              stop_good;

    uart_sync2 #(
        .reset_value (UART_IDLE_LEVEL)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (in_rx),
        .q     (rx_s)
    );

    assign sample      = (cycle_count == '0);
    assign stop_good   = (state == STOP) && sample && (rx_s == UART_IDLE_LEVEL);
    assign out_rx_busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cycle_count   <= '0;
            bit_count     <= '0;
            shift_reg     <= '0;
            out_data      <= '0;
            out_valid     <= 1'b0;
            out_frame_err <= 1'b0;
        end else begin
            out_valid     <= 1'b0;
            out_frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (rx_s != UART_IDLE_LEVEL) begin
                        state       <= START;
                        cycle_count <= HALF_LOAD;
                    end
                end
                START: begin
                    if (sample) begin
                        if (rx_s == UART_IDLE_LEVEL) begin
                            // Line went back high before mid start bit: glitch.
                            state <= IDLE;
                        end else begin
                            state       <= DATA;
                            bit_count   <= '0;
                            cycle_count <= FULL_LOAD;
                        end
                    end else begin
                        cycle_count <= cycle_count - CW'(1);
                    end
                end
                DATA: begin
                    if (sample) begin
                        // LSB arrives first, so shifting right restores order.
                        shift_reg   <= {rx_s, shift_reg[7:1]};
                        bit_count   <= bit_count + 4'd1;
                        cycle_count <= FULL_LOAD;
                        if (bit_count == LAST_BIT) begin
                            state <= STOP;
                        end
                    end else begin
                        cycle_count <= cycle_count - CW'(1);
                    end
                end
                STOP: begin
                    if (sample) begin
                        // Leaving mid-stop-bit lets a back-to-back start edge
                        // be seen without losing a frame.
                        if (stop_good) begin
                            out_data  <= shift_reg;
                            out_valid <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            out_frame_err <= 1'b1;
                            state         <= BREAK;
                        end
                    end else begin
                        cycle_count <= cycle_count - CW'(1);
                    end
                end
                BREAK: begin
                    // A held-low line must not restart framing until it idles.
                    if (rx_s == UART_IDLE_LEVEL) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef UART_RX_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_sum <= '0;
        end else if (stop_good) begin
            out_sum <= out_sum + {24'd0, shift_reg};
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx (clocks_per_bit = 4)
module tb_uart_rx;

    localparam int CPB  = 4;
    localparam int HALF = CPB / 2;
    localparam int LAT  = 2 + HALF + 9 * CPB;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_rx = 1'b1;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_frame_err;
    logic        out_rx_busy;
`ifdef UART_RX_CHECKSUM_EN
    logic [31:0] out_sum;
`endif

    uart_rx #(
        .clocks_per_bit (CPB)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_rx         (in_rx),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_frame_err (out_frame_err),
`ifdef UART_RX_CHECKSUM_EN
        .out_sum       (out_sum),
`endif
        .out_rx_busy   (out_rx_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests = n_tests + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Pulse monitor: records every pulse with the edge index it followed.
    logic [7:0] vq[$];
    int         vedge[$];
    int         eedge[$];
    logic       prev_pulse = 1'b0;

    always @(negedge clk) begin
        if (out_valid) begin
            vq.push_back(out_data);
            vedge.push_back(cyc);
        end
        if (out_frame_err) eedge.push_back(cyc);
        if (out_valid || out_frame_err) begin
            check("pulse_exclusive", {31'd0, out_valid && out_frame_err}, 32'd0);
            check("pulse_not_back_to_back", {31'd0, prev_pulse}, 32'd0);
        end
        prev_pulse = out_valid || out_frame_err;
    end

    task automatic hold(input logic v, input int n);
        in_rx = v;
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; e0 is the index of the edge capturing the start bit.
    task automatic send_frame(input logic [7:0] d, input logic stop_v, input int stop_len,
                              output int e0);
        e0 = cyc + 1;
        hold(1'b0, CPB);
        for (int i = 0; i < 8; i++) hold(d[i], CPB);
        hold(stop_v, stop_len);
    endtask

    task automatic clear_mon();
        vq.delete();
        vedge.delete();
        eedge.delete();
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop_v;
        int         stop_len;
        int         gap;
        logic       exp_valid;
        logic [7:0] exp_data;
    } vec_t;

    vec_t       vecs[6];
    logic [7:0] exp_vd[$];
    int         exp_ve[$];
    int         exp_ee[$];

    initial begin
        int e0;
        int busy_cnt;

        vecs[0] = '{8'hA5, 1'b1, 4,  10, 1'b1, 8'hA5};
        vecs[1] = '{8'h00, 1'b1, 4,  0,  1'b1, 8'h00};
        vecs[2] = '{8'hFF, 1'b1, 4,  0,  1'b1, 8'hFF};
        vecs[3] = '{8'h5A, 1'b1, 4,  10, 1'b1, 8'h5A};
        vecs[4] = '{8'h3C, 1'b0, 50, 10, 1'b0, 8'h5A};
        vecs[5] = '{8'h81, 1'b1, 4,  10, 1'b1, 8'h81};

        // Reset state
        rst_n = 1'b0;
        in_rx = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_out_data", {24'd0, out_data}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_frame_err", {31'd0, out_frame_err}, 32'd0);
        check("rst_out_rx_busy", {31'd0, out_rx_busy}, 32'd0);
`ifdef UART_RX_CHECKSUM_EN
        check("rst_out_sum", out_sum, 32'd0);
`endif
        rst_n = 1'b1;
        hold(1'b1, 5);
        clear_mon();

        // Table: single byte, back-to-back run, framing error with break, recovery
        for (int i = 0; i < 6; i++) begin
            send_frame(vecs[i].data, vecs[i].stop_v, vecs[i].stop_len, e0);
            if (vecs[i].exp_valid) begin
                exp_vd.push_back(vecs[i].data);
                exp_ve.push_back(e0 + LAT);
            end else begin
                exp_ee.push_back(e0 + LAT);
            end
            hold(1'b1, vecs[i].gap);
            if (vecs[i].gap != 0) begin
                check($sformatf("vec%0d_out_data", i), {24'd0, out_data}, {24'd0, vecs[i].exp_data});
                check($sformatf("vec%0d_idle", i), {31'd0, out_rx_busy}, 32'd0);
            end
        end
        hold(1'b1, 5);
        check("valid_count", vq.size(), exp_vd.size());
        for (int i = 0; i < exp_vd.size() && i < vq.size(); i++) begin
            check($sformatf("valid%0d_data", i), {24'd0, vq[i]}, {24'd0, exp_vd[i]});
            check($sformatf("valid%0d_edge", i), vedge[i], exp_ve[i]);
        end
        check("err_count", eedge.size(), exp_ee.size());
        for (int i = 0; i < exp_ee.size() && i < eedge.size(); i++)
            check($sformatf("err%0d_edge", i), eedge[i], exp_ee[i]);

        // One-clock low glitch on an idle line
        clear_mon();
        hold(1'b0, 1);
        in_rx = 1'b1;
        busy_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_rx_busy) busy_cnt++;
        end
        check("glitch_busy_cycles", busy_cnt, 32'd2);
        check("glitch_no_valid", vq.size(), 32'd0);
        check("glitch_no_err", eedge.size(), 32'd0);
        check("glitch_idle", {31'd0, out_rx_busy}, 32'd0);

        // Reset during data bit 4 of 0xC3, then 0x11
        hold(1'b0, CPB);
        for (int i = 0; i < 4; i++) hold(((8'hC3 >> i) & 8'h01) != 0, CPB);
        hold(1'b0, 2);
        rst_n = 1'b0;
        #1;
        check("midrst_out_data", {24'd0, out_data}, 32'd0);
        check("midrst_busy", {31'd0, out_rx_busy}, 32'd0);
        check("midrst_valid", {31'd0, out_valid}, 32'd0);
`ifdef UART_RX_CHECKSUM_EN
        check("midrst_sum", out_sum, 32'd0);
`endif
        in_rx = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        hold(1'b1, 10);
        check("midrst_no_pulse", vq.size() + eedge.size(), 32'd0);
        send_frame(8'h11, 1'b1, 4, e0);
        hold(1'b1, 10);
        check("after_rst_count", vq.size(), 32'd1);
        if (vq.size() > 0) begin
            check("after_rst_data", {24'd0, vq[0]}, 32'h11);
            check("after_rst_edge", vedge[0], e0 + LAT);
        end

`ifdef UART_RX_CHECKSUM_EN
        check("sum_after_11", out_sum, 32'h11);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        hold(1'b1, 5);
        for (int i = 0; i < 3; i++) begin
            send_frame(8'hFF, 1'b1, 4, e0);
            hold(1'b1, 10);
        end
        send_frame(8'h01, 1'b1, 4, e0);
        hold(1'b1, 10);
        check("sum_0x300", out_sum, 32'h300);
        send_frame(8'h3C, 1'b0, 50, e0);
        hold(1'b1, 10);
        check("sum_after_ferr", out_sum, 32'h300);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver matching the existing 8N1 transmitter.
- Frame format: line idles high; start bit 0; 8 data bits LSB-first; stop bit 1. Every bit lasts `clocks_per_bit` clocks.
- Synchronises the asynchronous `in_rx` line, detects and qualifies start bits, samples at mid-bit and presents each byte with a one-cycle valid pulse.
- Sits at the chip boundary opposite a transmitter, typically feeding a FIFO or command decoder.

Parameters:
- `clocks_per_bit`, 4, clocks per serial bit; legal range 2..65535; must equal the transmitter's value.

Ports:
- `clk`  in  1  system clock; all state updates on posedge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_rx`  in  1  serial line; asynchronous to `clk`; idle high.
- `out_data`  out  8  last correctly framed byte; held until the next good frame.
- `out_valid`  out  1  one-cycle pulse: `out_data` updated this cycle.
- `out_frame_err`  out  1  one-cycle pulse: stop bit sampled as 0.
- `out_rx_busy`  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: `out_data`=0, `out_valid`=0, `out_frame_err`=0, `out_rx_busy`=0. Both synchroniser flops =1. State=IDLE. Counters=0.
- Synchroniser: two flops give `rx_s`. Edge 0 is the first edge that captures `in_rx`=0; `rx_s` reads 0 after edge 1.
- Constants: `HALF` = `clocks_per_bit`/2 (floor). `cycle_count` width is $clog2(`clocks_per_bit`). `bit_count` is 4 bits.
- Sample rule: after a reload, `cycle_count` decrements by 1 each clock. The sample action fires on the edge where `cycle_count`==0.
- IDLE:
  - On the edge where `rx_s`==0: go to START and load `cycle_count`=`HALF`-1.
- START: at sample,
  - if `rx_s`==1: glitch; return to IDLE; no pulse.
  - else: go to DATA; `bit_count`=0; `cycle_count`=`clocks_per_bit`-1.
- DATA: at sample,
  - shift `rx_s` into bit 7 of the shift register (shift right, so LSB-first order is restored).
  - `bit_count`++; reload `cycle_count`.
  - after the 8th bit, go to STOP.
- STOP: at sample,
  - if `rx_s`==1: `out_data`<=shift register; `out_valid`<=1; go to IDLE.
  - else: `out_frame_err`<=1; `out_data` unchanged; go to BREAK.
- BREAK: wait for `rx_s`==1, then go to IDLE. A held-low line (break condition) gives exactly one error pulse, not repeated frames.
- Latency: the stop sample occurs on edge `E` = 2+`HALF`+9*`clocks_per_bit`. `out_valid` / `out_frame_err` are high for exactly the one cycle following edge `E`.
  - For `clocks_per_bit`=4: `E`=40.
- Pulses: `out_valid` and `out_frame_err` are mutually exclusive and never high on two consecutive cycles.
- Back-to-back frames: a start edge arriving immediately after the stop bit's nominal end must be accepted with no lost frame. IDLE is re-entered mid-stop-bit.
- Reset mid-frame: all state and outputs return to reset values immediately. The partial byte is discarded. The next frame begins from a fresh falling edge.
- No sampling occurs in IDLE or BREAK other than the state's own condition.

Optional Feature:
- Macro: `UART_RX_CHECKSUM_EN`.
- Defined:
  - adds output `out_sum` (32 bits, reset 0).
  - on each `out_valid`, `out_sum` <= `out_sum` + `out_data` (new byte), wrapping modulo 2^32.
  - framing errors do not accumulate.
- Undefined: the port and its adder are absent; all other behaviour is identical.

Decomposition:
- Package `uart_pkg`: state enum (IDLE, START, DATA, STOP, BREAK) as a 3-bit typedef; constants `UART_DATA_BITS`=8, `UART_IDLE_LEVEL`=1. The transmitter may later share the package.
- One sub-module, `uart_sync2`: a 2-flop synchroniser with a reset-value parameter (here 1). Reusable for other asynchronous inputs.

Test Plan (`clocks_per_bit`=4, driven by the existing transmitter or a bit-accurate model):
- Single byte 0xA5 → one `out_valid` pulse after edge 40; `out_data`=0xA5; `out_frame_err` never high.
- Back-to-back bytes 0x00, 0xFF, 0x5A with no idle gap → exactly three `out_valid` pulses, values in order; spacing 40 clocks.
- Low glitch of 1 clock on an idle line → stays/returns to IDLE; no pulses; `out_rx_busy` high for at most `HALF`+2 cycles.
- Frame 0x3C with stop bit forced 0, line then held low 50 clocks, then high → one `out_frame_err` pulse; `out_data` keeps its previous value; then 0x81 is received correctly.
- `rst_n` asserted during data bit 4 of 0xC3 → outputs reset immediately; no pulse; next frame 0x11 is received correctly.
- With `UART_RX_CHECKSUM_EN`: bytes 0xFF ×3 then 0x01 → `out_sum` = 0x300 after the fourth pulse; a framing-error frame leaves `out_sum` unchanged.
